// File: rtl/bp_stream_byte_packer_pkg.sv
// Shared defaults and helpers for the stream byte packer.
// Imported by the packer top.
package bp_stream_byte_packer_pkg;

   localparam int BP_IN_WIDTH_DEF  = 8;
   localparam int BP_OUT_WIDTH_DEF = 32;

   function automatic logic [31:0] bp_sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/bp_stream_byte_packer_if.sv
// Byte-in / word-out handshake bundle for the stream byte packer.
// slave is the packer side, master is the producer/consumer side.
interface bp_stream_byte_packer_if #(
   parameter int in_width_p          = 8,
   parameter int stream_data_width_p = 32
) ();

   logic                           byte_v_i;
   logic [in_width_p-1:0]          byte_data_i;
   logic                           byte_ready_o;
   logic                           flush_i;
   logic                           stream_v_o;
   logic [stream_data_width_p-1:0] stream_data_o;
   logic                           stream_ready_i;
   logic [31:0]                    word_count_o;
   logic                           busy_o;

   modport slave (
      input  byte_v_i, byte_data_i, flush_i, stream_ready_i,
      output byte_ready_o, stream_v_o, stream_data_o,
      output word_count_o, busy_o
   );

   modport master (
      output byte_v_i, byte_data_i, flush_i, stream_ready_i,
      input  byte_ready_o, stream_v_o, stream_data_o,
      input  word_count_o, busy_o
   );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO with async active-low reset.
// Enqueue into a full FIFO is legal only alongside a dequeue.
module bsg_two_fifo #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] r_mem [2];
   logic               r_rd;
   logic               r_wr;
   logic [1:0]         r_cnt;
   logic               w_enq;
   logic               w_deq;

   assign ready_o = (r_cnt != 2'd2);
   assign v_o     = (r_cnt != 2'd0);
   assign data_o  = r_mem[r_rd];
   assign w_deq   = yumi_i & v_o;
   assign w_enq   = v_i & (ready_o | w_deq);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_enq) begin
            r_mem[r_wr] <= data_i;
            r_wr        <= ~r_wr;
         end
         if (w_deq)
            r_rd <= ~r_rd;
         if (w_enq && !w_deq)
            r_cnt <= r_cnt + 2'd1;
         else if (w_deq && !w_enq)
            r_cnt <= r_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/bp_stream_byte_packer.sv
// Packs narrow lanes little-endian into words, with flush of partial
// words and a two-entry output buffer.
import bp_stream_byte_packer_pkg::*;

module bp_stream_byte_packer #(
   parameter int in_width_p          = BP_IN_WIDTH_DEF,
   parameter int stream_data_width_p = BP_OUT_WIDTH_DEF
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   bp_stream_byte_packer_if.slave bus
);

   localparam int els_lp    = stream_data_width_p / in_width_p;
   localparam int lg_els_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
   localparam logic [lg_els_lp-1:0] last_lp = lg_els_lp'(els_lp - 1);

   logic [lg_els_lp-1:0]           r_lane;
   logic [lg_els_lp-1:0]           w_lane_nxt;
   logic [stream_data_width_p-1:0] r_acc;
   logic [stream_data_width_p-1:0] w_acc_ins;
   logic [stream_data_width_p-1:0] w_acc_nxt;
   logic [stream_data_width_p-1:0] w_enq_data;
   logic                           r_flush_pend;
   logic                           w_flush_nxt;
   logic                           r_live;
   logic [31:0]                    r_count;
   logic                           w_fifo_ready;
   logic                           w_fifo_v;
   logic                           w_ready;
   logic                           w_accept;
   logic                           w_last;
   logic                           w_enq_word;
   logic                           w_enq_flush;
   logic                           w_enq;
   logic                           w_deq;

   // r_live holds ready low through reset and until the first clock edge
   assign w_last      = (r_lane == last_lp);
   assign w_ready     = r_live & ~r_flush_pend & ~(w_last & ~w_fifo_ready);
   assign w_accept    = bus.byte_v_i & w_ready;
   assign w_enq_word  = w_accept & w_last;
   assign w_enq_flush = r_flush_pend & w_fifo_ready;
   assign w_enq       = w_enq_word | w_enq_flush;
   assign w_enq_data  = w_enq_word ? w_acc_ins : r_acc;
   assign w_deq       = w_fifo_v & bus.stream_ready_i;

   always_comb begin
      w_acc_ins = r_acc;
      for (int k = 0; k < els_lp; k++)
         if (w_accept && (r_lane == lg_els_lp'(k)))
            w_acc_ins[k*in_width_p +: in_width_p] = bus.byte_data_i;
   end

   // a flush only arms when lanes remain filled after this cycle's byte
   always_comb begin
      w_lane_nxt  = r_lane;
      w_acc_nxt   = w_acc_ins;
      w_flush_nxt = r_flush_pend;
      if (w_enq) begin
         w_lane_nxt  = '0;
         w_acc_nxt   = '0;
         w_flush_nxt = 1'b0;
      end else if (w_accept) begin
         w_lane_nxt = r_lane + 1'b1;
      end
      if (bus.flush_i && !r_flush_pend && (w_lane_nxt != '0))
         w_flush_nxt = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_live       <= 1'b0;
         r_lane       <= '0;
         r_acc        <= '0;
         r_flush_pend <= 1'b0;
         r_count      <= '0;
      end else begin
         r_live       <= 1'b1;
         r_lane       <= w_lane_nxt;
         r_acc        <= w_acc_nxt;
         r_flush_pend <= w_flush_nxt;
         if (w_deq)
            r_count <= bp_sat_inc32(r_count);
      end
   end

   bsg_two_fifo #(
      .width_p (stream_data_width_p)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (w_enq),
      .data_i    (w_enq_data),
      .ready_o   (w_fifo_ready),
      .v_o       (w_fifo_v),
      .data_o    (bus.stream_data_o),
      .yumi_i    (w_deq)
   );

   assign bus.byte_ready_o = w_ready;
   assign bus.stream_v_o   = w_fifo_v;
   assign bus.word_count_o = r_count;
   assign bus.busy_o       = (r_lane != '0) | w_fifo_v | r_flush_pend;

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Self-checking bench for bp_stream_byte_packer: vector table,
// corner-case sequences and a byte-level scoreboard.
module tb_bp_stream_byte_packer;

   typedef struct {
      logic [31:0] bytes;
      int          n;
      bit          fl_last;
      bit          fl_after;
      logic [31:0] exp_word;
      int          exp_out;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_stream_byte_packer_if #(
      .in_width_p          (8),
      .stream_data_width_p (32)
   ) bus ();

   bp_stream_byte_packer #(
      .in_width_p          (8),
      .stream_data_width_p (32)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_out = 0;
   bit          rand_bp = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] out_log[$];
   logic [31:0] last_word = '0;
   logic [31:0] m_acc = '0;
   int          m_lane = 0;
   int          exp_wc = 0;
   vec_t        tbl[7];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // byte-level reference: bytes in, words out, in transfer order
   always @(negedge clk) begin
      if (!rst_n) begin
         m_lane = 0;
         m_acc  = '0;
         exp_q.delete();
      end else begin
         if (bus.stream_v_o && bus.stream_ready_i) begin
            last_word = bus.stream_data_o;
            out_log.push_back(bus.stream_data_o);
            n_out++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL sb_extra: got word %h, expected none",
                        bus.stream_data_o);
            end else begin
               chk("sb_word", bus.stream_data_o, exp_q.pop_front());
            end
         end
         if (bus.byte_v_i && bus.byte_ready_o) begin
            m_acc[m_lane*8 +: 8] = bus.byte_data_i;
            if (m_lane == 3) begin
               exp_q.push_back(m_acc);
               m_acc  = '0;
               m_lane = 0;
            end else begin
               m_lane++;
            end
         end
         if (bus.flush_i && m_lane != 0) begin
            exp_q.push_back(m_acc);
            m_acc  = '0;
            m_lane = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_bp)
         bus.stream_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [7:0] d, input bit fl);
      bit got;
      got = 1'b0;
      bus.byte_v_i    = 1'b1;
      bus.byte_data_i = d;
      bus.flush_i     = fl;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         got = bus.byte_ready_o;
         tick();
      end
      bus.flush_i = 1'b0;
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL byte_timeout: byte %h not accepted, expected accept",
                  d);
      end
   endtask

   task automatic idle(input int n);
      bus.byte_v_i = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_wc = 0;
      @(negedge clk);
      chk("rst_stream_v", 32'(bus.stream_v_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_word_count", bus.word_count_o, 32'd0);
      chk("rst_ready", 32'(bus.byte_ready_o), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", 32'(bus.byte_ready_o), 32'd0);
      tick();
      @(negedge clk);
      chk("ready_after_edge", 32'(bus.byte_ready_o), 32'd1);
      tick();
   endtask

   initial begin
      int base;
      bus.byte_v_i       = 1'b0;
      bus.byte_data_i    = '0;
      bus.flush_i        = 1'b0;
      bus.stream_ready_i = 1'b1;

      tbl[0] = '{32'h44332211, 4, 1'b0, 1'b0, 32'h44332211, 1};
      tbl[1] = '{32'h0000BBAA, 2, 1'b0, 1'b1, 32'h0000BBAA, 1};
      tbl[2] = '{32'h000000CC, 1, 1'b1, 1'b0, 32'h000000CC, 1};
      tbl[3] = '{32'h00000000, 0, 1'b0, 1'b1, 32'h00000000, 0};
      tbl[4] = '{32'h00030201, 3, 1'b0, 1'b1, 32'h00030201, 1};
      tbl[5] = '{32'hD4C3B2A1, 4, 1'b1, 1'b0, 32'hD4C3B2A1, 1};
      tbl[6] = '{32'h00000000, 0, 1'b0, 1'b1, 32'h00000000, 0};

      #2;
      do_reset();

      foreach (tbl[v]) begin
         base = n_out;
         for (int i = 0; i < tbl[v].n; i++)
            send(tbl[v].bytes[i*8 +: 8], tbl[v].fl_last && i == tbl[v].n-1);
         bus.byte_v_i = 1'b0;
         if (tbl[v].n == 4) begin
            @(negedge clk);
            chk($sformatf("latency_%0d", v), 32'(bus.stream_v_o), 32'd1);
            tick();
         end
         if (tbl[v].fl_after) begin
            bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
         end
         idle(8);
         exp_wc += tbl[v].exp_out;
         chk($sformatf("out_count_%0d", v), 32'(n_out - base),
             32'(tbl[v].exp_out));
         if (tbl[v].exp_out > 0)
            chk($sformatf("word_%0d", v), last_word, tbl[v].exp_word);
         @(negedge clk);
         chk($sformatf("word_count_%0d", v), bus.word_count_o, 32'(exp_wc));
         chk($sformatf("idle_busy_%0d", v), 32'(bus.busy_o), 32'd0);
         tick();
      end

      // backpressure: two words buffered, third word stalls on its last lane
      out_log.delete();
      bus.stream_ready_i = 1'b0;
      for (int i = 0; i < 8; i++)
         send(8'(i), 1'b0);
      bus.byte_v_i = 1'b0;
      @(negedge clk);
      chk("bp_stream_v", 32'(bus.stream_v_o), 32'd1);
      chk("bp_no_output", 32'(out_log.size()), 32'd0);
      tick();
      for (int i = 8; i < 11; i++)
         send(8'(i), 1'b0);
      bus.byte_v_i    = 1'b1;
      bus.byte_data_i = 8'h0B;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(bus.byte_ready_o), 32'd0);
         tick();
      end
      bus.stream_ready_i = 1'b1;
      send(8'h0B, 1'b0);
      idle(8);
      chk("bp_out_count", 32'(out_log.size()), 32'd3);
      if (out_log.size() == 3) begin
         chk("bp_word0", out_log[0], 32'h03020100);
         chk("bp_word1", out_log[1], 32'h07060504);
         chk("bp_word2", out_log[2], 32'h0B0A0908);
      end

      // reset mid-word discards the held bytes
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      send(8'h77, 1'b0);
      bus.byte_v_i = 1'b0;
      do_reset();
      out_log.delete();
      for (int i = 1; i <= 4; i++)
         send(8'(i), 1'b0);
      idle(8);
      chk("rst_out_count", 32'(out_log.size()), 32'd1);
      if (out_log.size() == 1)
         chk("rst_word", out_log[0], 32'h04030201);
      @(negedge clk);
      chk("rst_word_count_after", bus.word_count_o, 32'd1);
      tick();

      // random backpressure soak
      do_reset();
      rand_bp = 1'b1;
      for (int i = 0; i < 10000; i++)
         send(8'($urandom_range(0, 255)), 1'b0);
      bus.byte_v_i = 1'b0;
      rand_bp = 1'b0;
      bus.stream_ready_i = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() != 0; c++)
         tick();
      idle(4);
      chk("soak_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("soak_word_count", bus.word_count_o, 32'd2500);
      chk("soak_busy", 32'(bus.busy_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
